// File: rtl/pid_sched.sv
// PID measurement scheduler: on each round trigger, reads battery, current and
// torque from the A2D in turn, then registers the current-loop error.
`timescale 1ns/1ps
module pid_sched #(
  parameter bit          FAST_SIM   = 1'b0,
  parameter logic [11:0] BATT_THRES = 12'hA98
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               conv_req,
  output logic [2:0]         chnl,
  input  logic               conv_done,
  input  logic [11:0]        conv_res,
  input  logic [11:0]        target_curr,
  output logic [11:0]        batt,
  output logic [11:0]        torque,
  output logic [11:0]        curr_avg,
  output logic signed [12:0] error,
  output logic               err_vld,
  output logic               batt_low,
  output logic               ovr
);

  localparam int CW = FAST_SIM ? 15 : 20;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, CALC} state_t;
  typedef enum logic [1:0] {SLOT_BATT, SLOT_CURR, SLOT_TORQ} slot_t;

  logic [CW-1:0] cnt;
  logic          trig;
  state_t        state, state_nxt;
  slot_t         slot, slot_nxt;
  logic          capture, calc, ovr_set;
  logic [13:0]   avg_sum;
  logic [12:0]   diff;

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CW'(1);
  end

  assign trig = &cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= SLOT_BATT;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    conv_req  = 1'b0;
    capture   = 1'b0;
    calc      = 1'b0;
    case (state)
      IDLE: if (trig) begin
        state_nxt = REQ;
        slot_nxt  = SLOT_BATT;
      end
      REQ: begin
        conv_req  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (conv_done) begin
        capture = 1'b1;
        if (slot == SLOT_TORQ) begin
          state_nxt = CALC;
        end else begin
          state_nxt = REQ;
          slot_nxt  = (slot == SLOT_BATT) ? SLOT_CURR : SLOT_TORQ;
        end
      end
      CALC: begin
        calc      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A trigger that finds the FSM busy (CALC included) is an overrun.
  assign ovr_set = trig && (state != IDLE);

  always_comb begin
    chnl = 3'd0;
    case (slot)
      SLOT_CURR: chnl = 3'd1;
      SLOT_TORQ: chnl = 3'd4;
      default:   chnl = 3'd0;
    endcase
  end

  assign avg_sum = {1'b0, curr_avg, 1'b0} + {2'b00, curr_avg} + {2'b00, conv_res};
  assign diff    = {1'b0, target_curr} - {1'b0, curr_avg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt     <= '0;
      torque   <= '0;
      curr_avg <= '0;
      batt_low <= 1'b0;
      error    <= '0;
      err_vld  <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      err_vld <= calc;
      if (ovr_set) ovr <= 1'b1;
      if (calc) error <= batt_low ? '0 : signed'(diff);
      if (capture) begin
        case (slot)
          SLOT_BATT: begin
            batt     <= conv_res;
            batt_low <= (conv_res < BATT_THRES);
          end
          SLOT_CURR: curr_avg <= avg_sum[13:2];
          default:   torque   <= conv_res;
        endcase
      end
    end
  end

endmodule
